// File: rtl/cycle_watchdog.sv
// Run supervisor: counts cycles of a run armed by start, reports pass on done or fail on budget expiry.
// Optional heartbeat supervision is compiled in with `define CYCLE_WATCHDOG_KICK_EN.
//
// state | meaning
// IDLE  | waiting for start, cycles held at 0
// RUN   | counting run cycles, watching done / budget / heartbeat
// PASS  | done seen, cycles frozen until reset
// FAIL  | budget or heartbeat expired, cycles frozen until reset
module cycle_watchdog #(
  parameter int p_timeout_period = 10000,
  parameter int p_kick_window    = 256,
  parameter int p_cnt_width      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   done,
  input  logic                   kick,
  output logic [p_cnt_width-1:0] cycles,
  output logic                   running,
  output logic                   passed,
  output logic                   timeout_occurred,
  output logic                   kick_timeout
);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  localparam logic [p_cnt_width-1:0] c_budget = p_cnt_width'(p_timeout_period);
  localparam logic [p_cnt_width-1:0] c_one    = p_cnt_width'(1);

  state_t                 state, state_next;
  logic [p_cnt_width-1:0] cycles_q, cycles_next;
  logic                   timeout_q, timeout_next;
  logic                   kick_to_q, kick_to_next;
  logic                   kick_expired;

`ifdef CYCLE_WATCHDOG_KICK_EN
  localparam int c_kw = $clog2(p_kick_window + 1);
  localparam logic [c_kw-1:0] c_kick_limit = c_kw'(p_kick_window);
  localparam logic [c_kw-1:0] c_kick_one   = c_kw'(1);

  logic [c_kw-1:0] kick_cnt, kick_cnt_next;

  assign kick_expired = (kick_cnt == c_kick_limit) && !kick;

  always_ff @(posedge clk) begin
    if (reset) kick_cnt <= '0;
    else       kick_cnt <= kick_cnt_next;
  end

  // Counter only moves while the run continues; held in every other state.
  always_comb begin
    kick_cnt_next = kick_cnt;
    if (state == IDLE && start)
      kick_cnt_next = '0;
    else if (state == RUN && state_next == RUN)
      kick_cnt_next = kick ? '0 : kick_cnt + c_kick_one;
  end
`else
  logic unused_kick;
  assign unused_kick  = kick;
  assign kick_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
      kick_to_q <= 1'b0;
    end else begin
      state     <= state_next;
      cycles_q  <= cycles_next;
      timeout_q <= timeout_next;
      kick_to_q <= kick_to_next;
    end
  end

  always_comb begin
    state_next   = state;
    cycles_next  = cycles_q;
    timeout_next = timeout_q;
    kick_to_next = kick_to_q;
    case (state)
      IDLE: begin
        cycles_next = '0;
        if (start) state_next = RUN;
      end
      RUN: begin
        if (done) begin
          state_next = PASS;
        end else if (cycles_q == c_budget) begin
          state_next   = FAIL;
          timeout_next = 1'b1;
        end else if (kick_expired) begin
          state_next   = FAIL;
          kick_to_next = 1'b1;
        end else begin
          cycles_next = cycles_q + c_one;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cycles           = cycles_q;
    running          = (state == RUN);
    passed           = (state == PASS);
    timeout_occurred = timeout_q;
`ifdef CYCLE_WATCHDOG_KICK_EN
    kick_timeout     = kick_to_q;
`else
    kick_timeout     = 1'b0;
`endif
  end

`ifndef CYCLE_WATCHDOG_KICK_EN
  logic unused_kick_to;
  assign unused_kick_to = kick_to_q;
`endif

endmodule

// File: tb/tb_cycle_watchdog.sv
// Directed self-checking bench for cycle_watchdog (budget 20, kick window 5).
// Expectations for the heartbeat scenario follow CYCLE_WATCHDOG_KICK_EN.
module tb_cycle_watchdog;

  localparam int T = 20;
  localparam int W = 5;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset, start, done, kick;
  logic [CW-1:0] cycles;
  logic          running, passed, timeout_occurred, kick_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  cycle_watchdog #(
    .p_timeout_period(T),
    .p_kick_window   (W),
    .p_cnt_width     (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .done            (done),
    .kick            (kick),
    .cycles          (cycles),
    .running         (running),
    .passed          (passed),
    .timeout_occurred(timeout_occurred),
    .kick_timeout    (kick_timeout)
  );

  always #5 clk = ~clk;

  // Inputs change right after a falling edge; outputs are read there too.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; done = 1'b0; kick = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({running, passed, timeout_occurred, kick_timeout} !== 4'b0 || cycles !== '0) begin
      n_fail++;
      $display("FAIL reset_priority: flags=%b cycles=%0d required flags=0000 cycles=0",
               {running, passed, timeout_occurred, kick_timeout}, cycles);
    end
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({running, passed, timeout_occurred, kick_timeout} !== 4'b0 || cycles !== '0) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: flags=%b cycles=%0d required flags=0000 cycles=0",
                 i, {running, passed, timeout_occurred, kick_timeout}, cycles);
      end
    end
  endtask

  task automatic test_pass();
    do_reset();
    kick = 1'b1;
    start_run();
    n_checks++;
    if (running !== 1'b1 || cycles !== 0) begin
      n_fail++;
      $display("FAIL run_entry: running=%b cycles=%0d required running=1 cycles=0", running, cycles);
    end
    repeat (7) @(negedge clk);
    n_checks++;
    if (cycles !== 7) begin
      n_fail++;
      $display("FAIL count_to_7: cycles=%0d required 7", cycles);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      n_checks++;
      if (passed !== 1'b1 || running !== 1'b0 || timeout_occurred !== 1'b0 ||
          kick_timeout !== 1'b0 || cycles !== 7) begin
        n_fail++;
        $display("FAIL pass_frozen[%0d]: p=%b r=%b to=%b kt=%b cycles=%0d required p=1 r=0 to=0 kt=0 cycles=7",
                 i, passed, running, timeout_occurred, kick_timeout, cycles);
      end
      @(negedge clk);
    end
    kick = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    kick = 1'b1;
    start_run();
    for (int k = 1; k <= T; k++) begin
      @(negedge clk);
      n_checks++;
      if (cycles !== k || running !== 1'b1 || timeout_occurred !== 1'b0) begin
        n_fail++;
        $display("FAIL budget_count[%0d]: cycles=%0d r=%b to=%b required cycles=%0d r=1 to=0",
                 k, cycles, running, timeout_occurred, k);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (timeout_occurred !== 1'b1 || passed !== 1'b0 || running !== 1'b0 ||
          kick_timeout !== 1'b0 || cycles !== T) begin
        n_fail++;
        $display("FAIL timeout_frozen[%0d]: to=%b p=%b r=%b kt=%b cycles=%0d required to=1 p=0 r=0 kt=0 cycles=%0d",
                 i, timeout_occurred, passed, running, kick_timeout, cycles, T);
      end
    end
    kick = 1'b0;
  endtask

  task automatic test_done_at_budget();
    do_reset();
    kick = 1'b1;
    start_run();
    repeat (T) @(negedge clk);
    n_checks++;
    if (cycles !== T) begin
      n_fail++;
      $display("FAIL reach_budget: cycles=%0d required %0d", cycles, T);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (passed !== 1'b1 || timeout_occurred !== 1'b0 || running !== 1'b0 || cycles !== T) begin
      n_fail++;
      $display("FAIL done_at_budget: p=%b to=%b r=%b cycles=%0d required p=1 to=0 r=0 cycles=%0d",
               passed, timeout_occurred, running, cycles, T);
    end
    kick = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    kick = 1'b1;
    start_run();
    repeat (10) @(negedge clk);
    n_checks++;
    if (cycles !== 10) begin
      n_fail++;
      $display("FAIL mid_run_count: cycles=%0d required 10", cycles);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({running, passed, timeout_occurred, kick_timeout} !== 4'b0 || cycles !== '0) begin
        n_fail++;
        $display("FAIL abort_idle[%0d]: flags=%b cycles=%0d required flags=0000 cycles=0",
                 i, {running, passed, timeout_occurred, kick_timeout}, cycles);
      end
      @(negedge clk);
    end
    start_run();
    n_checks++;
    if (running !== 1'b1 || cycles !== 0) begin
      n_fail++;
      $display("FAIL restart_entry: r=%b cycles=%0d required r=1 cycles=0", running, cycles);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (cycles !== 3) begin
      n_fail++;
      $display("FAIL restart_count: cycles=%0d required 3", cycles);
    end
    kick = 1'b0;
  endtask

  task automatic test_kick();
    int budget;
    do_reset();
    kick = 1'b0;
    start_run();
    budget = 0;
    while (running === 1'b1 && budget < 40) begin
      kick = (cycles == 3 || cycles == 6 || cycles == 9);
      @(negedge clk);
      budget++;
    end
    kick = 1'b0;
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL kick_run_end: running=%b after %0d cycles required 0", running, budget);
    end
`ifdef CYCLE_WATCHDOG_KICK_EN
    n_checks++;
    if (kick_timeout !== 1'b1 || timeout_occurred !== 1'b0 || passed !== 1'b0 || cycles !== 15) begin
      n_fail++;
      $display("FAIL kick_expiry: kt=%b to=%b p=%b cycles=%0d required kt=1 to=0 p=0 cycles=15",
               kick_timeout, timeout_occurred, passed, cycles);
    end
`else
    n_checks++;
    if (kick_timeout !== 1'b0 || timeout_occurred !== 1'b1 || passed !== 1'b0 || cycles !== T) begin
      n_fail++;
      $display("FAIL kick_ignored: kt=%b to=%b p=%b cycles=%0d required kt=0 to=1 p=0 cycles=%0d",
               kick_timeout, timeout_occurred, passed, cycles, T);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; done = 1'b0; kick = 1'b0;
    @(negedge clk);
    test_reset();
    test_pass();
    test_timeout();
    test_done_at_budget();
    test_reset_mid_run();
    test_kick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cycle_watchdog.md
Name: cycle_watchdog

Overview:
- Synthesizable run-supervisor that sits on the consuming end of the bench clock/reset/timeout interface.
- Takes clk and reset, plus start/done handshakes from the test sequencer and DUT.
- Counts run cycles and declares pass, or fail on a global cycle budget.
- Lets a DUT-side or FPGA-side harness own its own timeout, replacing a behavioural generator.

Parameters:
- p_timeout_period, 10000, run-cycle budget; FAIL once cycles reaches this value without done.
- p_kick_window, 256, maximum cycles between kicks (used only with the optional feature).
- p_cnt_width, 32, width of the cycle counter. Must satisfy 2^p_cnt_width > p_timeout_period.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  level or pulse; arms a run when sampled high in IDLE.
- done  input  1  DUT completion; sampled only in RUN.
- kick  input  1  heartbeat from DUT; sampled only in RUN.
- cycles  output  p_cnt_width  registered run-cycle count.
- running  output  1  high while in RUN.
- passed  output  1  sticky pass flag.
- timeout_occurred  output  1  sticky global-budget failure.
- kick_timeout  output  1  sticky heartbeat failure; tied 0 without the macro.

Behaviour:
- All outputs are registered. All state changes occur on the rising edge of clk.
- Reset: on any edge with reset=1, go to IDLE with cycles=0 and all flags 0. This applies in every state, including mid-RUN (the run is aborted, no flag is set). Reset has priority over every other input.
- States: IDLE, RUN, PASS, FAIL.
- IDLE:
  - start=1 -> RUN, cycles=0.
  - Otherwise stay in IDLE; cycles holds 0.
- RUN:
  - running=1.
  - The first RUN cycle shows cycles=0.
  - Each edge, evaluate in priority order:
    1. done=1 -> PASS, passed=1, cycles holds.
    2. Else if cycles==p_timeout_period -> FAIL, timeout_occurred=1, cycles holds.
    3. Else (optional feature only) if the kick counter has expired -> FAIL, kick_timeout=1.
    4. Else cycles+1.
  - start is ignored in RUN.
- PASS / FAIL:
  - Terminal until reset; start, done and kick are ignored.
  - cycles is frozen. running=0.
- Flag exclusivity: at most one of passed, timeout_occurred and kick_timeout is ever 1.
- Timeout timing: timeout_occurred rises exactly p_timeout_period+1 edges after RUN entry.
- Simultaneous done and budget expiry: PASS wins.
- cycles never wraps; the width rule above guarantees this.

Optional Feature:
- Macro: CYCLE_WATCHDOG_KICK_EN.
- With the macro:
  - An internal kick counter (width $clog2(p_kick_window+1)) clears on RUN entry and on any RUN cycle with kick=1, and otherwise increments.
  - When it equals p_kick_window with kick=0 and done=0, and the global budget has not expired, go to FAIL with kick_timeout=1.
  - Priority is done > global timeout > kick timeout.
  - The kick counter is held in IDLE, PASS and FAIL.
- Without the macro: no kick counter; the kick input is unused; kick_timeout is a constant 0. All other behaviour is identical.

Test Plan (p_timeout_period=20, p_kick_window=5):
- Reset for 2 cycles, then hold start=0 for 10 cycles -> cycles=0, running=0, all flags 0 throughout.
- Pulse start for 1 cycle; assert done in the RUN cycle where cycles=7 -> next edge passed=1, running=0, cycles=7 frozen for 10 further cycles. A later start is ignored.
- Pulse start; never assert done -> timeout_occurred=1 on the 21st edge after RUN entry, cycles=20 frozen, passed=0.
- Pulse start; assert done exactly in the cycle where cycles=20 -> passed=1, timeout_occurred=0.
- Pulse start; assert reset in the cycle where cycles=10 -> next edge IDLE with cycles=0 and flags 0. Pulse start again -> count restarts from 0.
- With CYCLE_WATCHDOG_KICK_EN: kick every 3rd cycle until cycles=9, then stop -> kick_timeout=1 once the kick counter reaches 5, timeout_occurred=0. Same stimulus without the macro -> timeout_occurred=1 at cycles=20, kick_timeout=0.
